read_resp_router: RTL
=====================

# read_resp_router

Returns AXI read-data (R channel) beats from the six slaves (S0 ROM, S1 IM, S2 DM, S3 DMA, S4 WDT, S5 DRAM) back to the single master port. It is the return-path counterpart of the address decoder. It arbitrates round-robin among slaves presenting RVALID and locks onto the granted slave until that slave's RLAST beat completes. Only the granted slave sees RREADY, so no beat is ever dropped or interleaved.

## Interface
- DATA_BITS, 32, RDATA width
- ID_BITS, 8, RID width
- ACLK  in  1  clock, all state updates on rising edge
- ARESETn  in  1  asynchronous active-low reset
- RID_Sx, RDATA_Sx, RRESP_Sx[1:0], RLAST_Sx, RVALID_Sx  in  per slave x=0..5  slave R channel
- RREADY_Sx  out  1 each (x=0..5)  ready to slave x
- RID_M  out  ID_BITS  forwarded ID
- RDATA_M  out  DATA_BITS  forwarded data
- RRESP_M  out  2  forwarded response
- RLAST_M  out  1  forwarded last
- RVALID_M  out  1  forwarded valid
- RREADY_M  in  1  master ready
- BUSY  out  1  high while a slave is granted
- GRANT  out  3  index of granted slave, 0..5; holds last grant when idle

## Operation
- Two-state FSM: IDLE, LOCK. Registers: state, sel[2:0], ptr[2:0] (round-robin start), all reset to IDLE/0/0.
- IDLE: all M outputs driven 0, all RREADY_Sx = 0. If any RVALID_Sx=1: sel <= first x with RVALID_Sx=1 searching ptr, ptr+1, ..., wrapping 5→0; state <= LOCK. If none valid, stay.
- LOCK: RID_M/RDATA_M/RRESP_M/RLAST_M/RVALID_M = slave[sel] signals (combinational). RREADY_S[sel] = RREADY_M; the other RREADY_Sx = 0.
- Beat handshake = RVALID_M & RREADY_M. On a handshake with RLAST_M=1: state <= IDLE, ptr <= (sel==5) ? 0 : sel+1. A handshake with RLAST_M=0 keeps LOCK.
- Slave deasserting RVALID mid-burst: stay in LOCK, RVALID_M follows (0), wait indefinitely; no rearbitration.
- RVALID from non-granted slaves is ignored while in LOCK; those slaves hold their beats (AXI rule) until granted.
- BUSY = (state==LOCK); GRANT = sel.
- sel/ptr never take values 6 or 7; the arithmetic wraps modulo 6 explicitly.

## Timing
- Reset (asynchronous, immediate on ARESETn low): state IDLE, sel 0, ptr 0, BUSY 0, GRANT 0, RVALID_M 0, RDATA_M/RID_M/RRESP_M/RLAST_M 0, all RREADY_Sx 0. Reset asserted mid-burst abandons the burst; the slave's pending beat is not acknowledged.
- Grant latency: RVALID_Sx first high in cycle t (IDLE) → LOCK and RVALID_M=1 in cycle t+1.
- Forwarding in LOCK is zero-latency combinational: a beat accepted in cycle c is handshaken with the slave in the same cycle c.
- After a RLAST handshake in cycle c: IDLE in c+1 (one bubble cycle, RVALID_M=0); the earliest next grant is LOCK in c+2.
- Burst of N beats with continuous valid/ready: occupies N+1 cycles (1 arbitration + N data).
- Simultaneous requests are resolved solely by ptr; no fixed priority.

## Test plan
- Single slave: S2 returns 4-beat burst RID=0x05, RDATA 0x11,0x22,0x33,0x44, RREADY_M=1 → LOCK 1 cycle after RVALID_S2, four beats forwarded in order, RREADY_S2 high only in LOCK, IDLE after 4th beat, ptr=3.
- All six RVALID_Sx high from reset, each 1-beat bursts with RLAST=1 → grants S0,S1,S2,S3,S4,S5, then wrap to S0; each grant spaced 2 cycles.
- Backpressure: S5 4-beat burst, RREADY_M toggles 1,0,0,1,... → no beat duplicated or lost; RREADY_S5 mirrors RREADY_M exactly; RLAST_M seen once.
- Competing request mid-burst: S1 bursting (ptr=0), S0 asserts RVALID in the 2nd beat → RREADY_S0 stays 0 until S1's RLAST; S0 is granted next (ptr=2 search wraps to 0 because S2..S5 are idle).
- Slave gap: S4 drops RVALID for 3 cycles mid-burst → RVALID_M=0 for those cycles, BUSY stays 1, GRANT=4.
- Reset mid-burst: ARESETn low during beat 2 of S3 → all outputs 0 immediately; after release, S3 is regranted from ptr=0 search, with S0..S2 idle.

Source files
------------

// File: rtl/read_resp_router.sv
// AXI R-channel return router: round-robin arbitration among six slaves,
// locked to the granted slave until its RLAST beat is accepted by the master.
module read_resp_router #(
    parameter int DATA_BITS = 32,
    parameter int ID_BITS   = 8
) (
    input  logic                 ACLK,
    input  logic                 ARESETn,
    input  logic [ID_BITS-1:0]   RID_S0,
    input  logic [DATA_BITS-1:0] RDATA_S0,
    input  logic [1:0]           RRESP_S0,
    input  logic                 RLAST_S0,
    input  logic                 RVALID_S0,
    output logic                 RREADY_S0,
    input  logic [ID_BITS-1:0]   RID_S1,
    input  logic [DATA_BITS-1:0] RDATA_S1,
    input  logic [1:0]           RRESP_S1,
    input  logic                 RLAST_S1,
    input  logic                 RVALID_S1,
    output logic                 RREADY_S1,
    input  logic [ID_BITS-1:0]   RID_S2,
    input  logic [DATA_BITS-1:0] RDATA_S2,
    input  logic [1:0]           RRESP_S2,
    input  logic                 RLAST_S2,
    input  logic                 RVALID_S2,
    output logic                 RREADY_S2,
    input  logic [ID_BITS-1:0]   RID_S3,
    input  logic [DATA_BITS-1:0] RDATA_S3,
    input  logic [1:0]           RRESP_S3,
    input  logic                 RLAST_S3,
    input  logic                 RVALID_S3,
    output logic                 RREADY_S3,
    input  logic [ID_BITS-1:0]   RID_S4,
    input  logic [DATA_BITS-1:0] RDATA_S4,
    input  logic [1:0]           RRESP_S4,
    input  logic                 RLAST_S4,
    input  logic                 RVALID_S4,
    output logic                 RREADY_S4,
    input  logic [ID_BITS-1:0]   RID_S5,
    input  logic [DATA_BITS-1:0] RDATA_S5,
    input  logic [1:0]           RRESP_S5,
    input  logic                 RLAST_S5,
    input  logic                 RVALID_S5,
    output logic                 RREADY_S5,
    output logic [ID_BITS-1:0]   RID_M,
    output logic [DATA_BITS-1:0] RDATA_M,
    output logic [1:0]           RRESP_M,
    output logic                 RLAST_M,
    output logic                 RVALID_M,
    input  logic                 RREADY_M,
    output logic                 BUSY,
    output logic [2:0]           GRANT
);

    typedef enum logic {IDLE, LOCK} state_t;

    state_t               r_state, w_state_nxt;
    logic [2:0]           r_sel, r_ptr, w_sel_nxt, w_ptr_nxt, w_sel_inc, w_pick;
    logic                 w_found;
    logic [3:0]           w_cand;
    logic [5:0]           w_rvalid, w_rlast, w_rready;
    logic [ID_BITS-1:0]   w_rid   [6];
    logic [DATA_BITS-1:0] w_rdata [6];
    logic [1:0]           w_rresp [6];

    assign w_rvalid = {RVALID_S5, RVALID_S4, RVALID_S3, RVALID_S2, RVALID_S1, RVALID_S0};
    assign w_rlast  = {RLAST_S5, RLAST_S4, RLAST_S3, RLAST_S2, RLAST_S1, RLAST_S0};
    assign w_rid    = '{RID_S0, RID_S1, RID_S2, RID_S3, RID_S4, RID_S5};
    assign w_rdata  = '{RDATA_S0, RDATA_S1, RDATA_S2, RDATA_S3, RDATA_S4, RDATA_S5};
    assign w_rresp  = '{RRESP_S0, RRESP_S1, RRESP_S2, RRESP_S3, RRESP_S4, RRESP_S5};
    assign {RREADY_S5, RREADY_S4, RREADY_S3, RREADY_S2, RREADY_S1, RREADY_S0} = w_rready;

    assign w_sel_inc = (r_sel == 3'd5) ? '0 : r_sel + 3'd1;
    assign BUSY      = (r_state == LOCK);
    assign GRANT     = r_sel;

    // Round-robin search starting at r_ptr, index wrapped modulo 6
    always_comb begin
        w_found = 1'b0;
        w_pick  = r_ptr;
        w_cand  = '0;
        for (int unsigned i = 0; i < 6; i++) begin
            w_cand = {1'b0, r_ptr} + 4'(i);
            if (w_cand >= 4'd6) w_cand = w_cand - 4'd6;
            if (!w_found && w_rvalid[w_cand[2:0]]) begin
                w_found = 1'b1;
                w_pick  = w_cand[2:0];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_ptr_nxt   = r_ptr;
        w_rready    = '0;
        RID_M       = '0;
        RDATA_M     = '0;
        RRESP_M     = '0;
        RLAST_M     = 1'b0;
        RVALID_M    = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_sel_nxt   = w_pick;
                    w_state_nxt = LOCK;
                end
            end
            LOCK: begin
                RID_M            = w_rid[r_sel];
                RDATA_M          = w_rdata[r_sel];
                RRESP_M          = w_rresp[r_sel];
                RLAST_M          = w_rlast[r_sel];
                RVALID_M         = w_rvalid[r_sel];
                w_rready[r_sel]  = RREADY_M;
                if (w_rvalid[r_sel] && RREADY_M && w_rlast[r_sel]) begin
                    w_state_nxt = IDLE;
                    w_ptr_nxt   = w_sel_inc;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state <= IDLE;
            r_sel   <= '0;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_sel   <= w_sel_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

endmodule
